// File: rtl/mac_sequencer_if.sv
// Handshake and data bundle for mac_sequencer: start/clr requests, operands,
// and the registered status/result returned by the sequencer.
interface mac_sequencer_if;
    logic        start;
    logic        clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        overflow;

    modport master (
        output start, clr, a, b, c, d,
        input  busy, done, sum, overflow
    );

    modport slave (
        input  start, clr, a, b, c, d,
        output busy, done, sum, overflow
    );
endinterface

// File: rtl/mac_sequencer.sv
// Computes S = A*B + C*D with one shared 8x8 shift-add multiplier over 19 cycles.
// Define MAC_SEQ_ACCUM_EN to accumulate into sum with a sticky overflow flag.
module mac_sequencer (
    input  logic            Clock,
    input  logic            Resetn,
    mac_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_AB = 3'd1,
        MUL_CD = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  ra, rb, rc, rd;
    logic [15:0] p0, p1;
    logic [15:0] mcand;
    logic [7:0]  mlr;
    logic [15:0] pp;
    logic [2:0]  cnt;
    logic [15:0] sum_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  sel_hi, sel_lo;
    logic [15:0] cur_mcand;
    logic [7:0]  cur_mlr;
    logic [15:0] pp_base;
    logic [15:0] pp_nxt;
    logic [15:0] sum_nxt;
    logic        ovf_nxt;

    // The first iteration of each product takes its operands straight from the
    // operand registers, so no separate load cycle is needed between products.
    always_comb begin
        sel_hi    = (state == MUL_AB) ? ra : rc;
        sel_lo    = (state == MUL_AB) ? rb : rd;
        cur_mcand = (cnt == 3'd0) ? {8'h00, sel_hi} : mcand;
        cur_mlr   = (cnt == 3'd0) ? sel_lo : mlr;
        pp_base   = (cnt == 3'd0) ? 16'h0000 : pp;
        pp_nxt    = pp_base + (cur_mlr[0] ? cur_mcand : 16'h0000);
    end

`ifdef MAC_SEQ_ACCUM_EN
    logic [17:0] acc;

    always_comb begin
        acc     = {2'b00, sum_q} + {2'b00, p0} + {2'b00, p1};
        sum_nxt = acc[15:0];
        ovf_nxt = ovf_q | acc[16] | acc[17];
    end
`else
    logic [16:0] add;

    always_comb begin
        add     = {1'b0, p0} + {1'b0, p1};
        sum_nxt = add[15:0];
        ovf_nxt = add[16];
    end
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            rc     <= '0;
            rd     <= '0;
            p0     <= '0;
            p1     <= '0;
            mcand  <= '0;
            mlr    <= '0;
            pp     <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.clr) begin
            state  <= IDLE;
            cnt    <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        ra     <= bus.a;
                        rb     <= bus.b;
                        rc     <= bus.c;
                        rd     <= bus.d;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= MUL_AB;
                    end
                end
                MUL_AB, MUL_CD: begin
                    mcand <= cur_mcand << 1;
                    mlr   <= cur_mlr >> 1;
                    pp    <= pp_nxt;
                    cnt   <= cnt + 3'd1;
                    // cnt wraps to 0 here, which restarts the next product
                    if (cnt == 3'd7) begin
                        if (state == MUL_AB) begin
                            p0    <= pp_nxt;
                            state <= MUL_CD;
                        end else begin
                            p1    <= pp_nxt;
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    sum_q  <= sum_nxt;
                    ovf_q  <= ovf_nxt;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: reset, products, overflow, ignored start,
// mid-operation clear and accumulate behaviour in either build.
module tb_mac_sequencer;

    logic Clock;
    logic Resetn;
    int   nvec = 0;
    int   nerr = 0;
    int   ndone, done_at, busy_bad;

    mac_sequencer_if bus ();

    mac_sequencer dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_clr;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    // Start at E0, then walk edges E1..E24. Operands are scrambled after E0;
    // start_at/clr_at inject a start or clr sampled at that edge (0 = none).
    task automatic run_op(input logic [7:0] ia, ib, ic, id,
                          input int start_at, input int clr_at,
                          output int nd, output int dat, output int bad);
        logic exp_busy;
        bus.a = ia; bus.b = ib; bus.c = ic; bus.d = id;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = ~ia; bus.b = ~ib; bus.c = ~ic; bus.d = ~id;
        nd = 0; dat = -1; bad = 0;
        for (int k = 1; k <= 24; k++) begin
            bus.start = (k == start_at);
            bus.clr   = (k == clr_at);
            if (k == start_at) begin
                bus.a = 8'hFF; bus.b = 8'hFF; bus.c = 8'hFF; bus.d = 8'hFF;
            end
            tick();
            bus.start = 1'b0;
            bus.clr   = 1'b0;
            if (bus.done) begin
                nd++;
                dat = k;
            end
            exp_busy = (clr_at > 0 && k >= clr_at) ? 1'b0 : (k <= 16);
            if (bus.busy !== exp_busy) bad++;
            if (bus.busy && bus.done) bad++;
        end
    endtask

    initial begin
        Resetn    = 1'b0;
        bus.start = 1'b1;
        bus.clr   = 1'b0;
        bus.a = 8'd3; bus.b = 8'd4; bus.c = 8'd5; bus.d = 8'd6;

        // reset held two edges with start high
        tick();
        tick();
        chk("rst_sum", bus.sum, 16'h0000);
        chk("rst_ovf", bus.overflow, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        bus.start = 1'b0;
        Resetn = 1'b1;
        tick();
        chk("rst_nostart", bus.busy, 1'b0);

        // basic 3*4 + 5*6 = 42
        run_op(8'd3, 8'd4, 8'd5, 8'd6, 0, 0, ndone, done_at, busy_bad);
        chk("basic_ndone", ndone, 1);
        chk("basic_lat", done_at, 17);
        chk("basic_busy", busy_bad, 0);
        chk("basic_sum", bus.sum, 16'h002A);
        chk("basic_ovf", bus.overflow, 1'b0);

        // overflow from a cleared result: 2*0xFE01 = 0x1FC02
        do_clr();
        chk("clr_sum", bus.sum, 16'h0000);
        run_op(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, ndone, done_at, busy_bad);
        chk("ovf1_ndone", ndone, 1);
        chk("ovf1_sum", bus.sum, 16'hFC02);
        chk("ovf1_ovf", bus.overflow, 1'b1);
        run_op(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, ndone, done_at, busy_bad);
`ifdef MAC_SEQ_ACCUM_EN
        chk("ovf2_sum", bus.sum, 16'hF804);
`else
        chk("ovf2_sum", bus.sum, 16'hFC02);
`endif
        chk("ovf2_ovf", bus.overflow, 1'b1);

        // clr at E10 aborts: no done, result and flag cleared
        run_op(8'd3, 8'd4, 8'd5, 8'd6, 0, 10, ndone, done_at, busy_bad);
        chk("abort_ndone", ndone, 0);
        chk("abort_busy", busy_bad, 0);
        chk("abort_sum", bus.sum, 16'h0000);
        chk("abort_ovf", bus.overflow, 1'b0);
        run_op(8'd3, 8'd4, 8'd5, 8'd6, 0, 0, ndone, done_at, busy_bad);
        chk("after_abort_lat", done_at, 17);
        chk("after_abort_sum", bus.sum, 16'h002A);

        // start at E5 ignored; 2*3 + 0*0 = 6
        do_clr();
        run_op(8'd2, 8'd3, 8'd0, 8'd0, 5, 0, ndone, done_at, busy_bad);
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", done_at, 17);
        chk("ign_busy", busy_bad, 0);
        chk("ign_sum", bus.sum, 16'h0006);
        chk("ign_ovf", bus.overflow, 1'b0);

        // 1*1 + 1*1 = 2, accumulated onto 6 when enabled
        run_op(8'd1, 8'd1, 8'd1, 8'd1, 0, 0, ndone, done_at, busy_bad);
`ifdef MAC_SEQ_ACCUM_EN
        chk("acc_sum", bus.sum, 16'h0008);
`else
        chk("acc_sum", bus.sum, 16'h0002);
`endif
        chk("acc_ovf", bus.overflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Multi-cycle controller that computes S = A·B + C·D using a single shared 8×8 shift-add multiplier, sequenced by a small state machine with a start/done handshake. Intended for the DE2 lab top levels in place of the two parallel hardware multipliers. Operand registers, the accumulator, and the overflow flag are owned by this block. The top level maps switches, keys, and seven-segment decoders onto its ports.

## Interface
- No parameters; widths are fixed at 8-bit operands and a 16-bit result.
- Clock  input  1  rising-edge system clock.
- Resetn  input  1  synchronous, active-low reset.
- start  input  1  request one computation; sampled only in IDLE.
- clr  input  1  synchronous clear of result, overflow and state; active-high.
- a, b, c, d  input  8 each  unsigned operands; captured on the accepting edge.
- busy  output  1  high while in MUL_AB, MUL_CD or ADD.
- done  output  1  one-cycle pulse; high only in DONE.
- sum  output  16  registered result.
- overflow  output  1  registered carry/overflow flag.

## Operation
- **Operand registers.** The block has internal operand registers rA, rB, rC and rD, all 8-bit.
- **Multiplier datapath.** The shift-add datapath uses:
  - a 16-bit multiplicand shift register,
  - an 8-bit multiplier shift register,
  - a 16-bit partial product,
  - a 3-bit iteration counter.
- **Product registers.** Products are held in P0 (A·B) and P1 (C·D), both 16-bit.
- **State machine.**
  - IDLE: if start=1, capture a/b/c/d and load the multiplier with rA, rB; go to MUL_AB.
  - MUL_AB: 8 iterations. Each iteration:
    - if the multiplier LSB is 1, add the multiplicand to the partial product;
    - shift the multiplicand left by 1;
    - shift the multiplier right by 1.
  - MUL_AB exit: after iteration 8, store the product in P0, load rC, rD, and go to MUL_CD.
  - MUL_CD: identical 8 iterations; after iteration 8, store the product in P1 and go to ADD.
  - ADD: compute the 17-bit value P0 + P1 (see Configuration for how sum and overflow are written); go to DONE.
  - DONE: done=1; go to IDLE unconditionally.
- **Ignored start.** start in any state other than IDLE is ignored and is not queued.
- **Clear.** clr=1 forces state IDLE and sets sum=0, overflow=0 and the counter to 0, on the next edge from any state. clr has priority over start.
- **Reset.** Resetn=0 has the same effect as clr and also zeroes rA–rD, P0 and P1.
- **Stable outputs.** sum and overflow change only on an ADD edge, clr, or reset. They hold their values while busy.
- **Operand changes.** Changing a–d after the accepting edge has no effect on the running computation.

## Timing
- **Reset values.** busy=0, done=0, sum=16'h0000, overflow=0; state IDLE.
- **Accepting edge.** Edge E0 is the edge that samples start=1 in IDLE. busy is high from after E0 until after E17.
- **Edge schedule.**
  - Iterations for A·B occupy edges E1–E8.
  - Iterations for C·D occupy edges E9–E16.
  - sum and overflow are updated at E17.
  - done is high for exactly the cycle between E17 and E18.
  - The block is back in IDLE after E18.
- **Latency and throughput.**
  - done is visible 17 cycles after E0.
  - The earliest next accepting edge is E19, because start is sampled at E18 while still in DONE and is ignored there.
  - Throughput is therefore one operation per 19 cycles when start is held high.
- **clr mid-operation.** clr during busy aborts the operation. No done pulse is produced and P0/P1 contents are don't-care.
- **Signal relationships.** busy and done are never high simultaneously.

## Configuration
- **Macro.** MAC_SEQ_ACCUM_EN.
- **Undefined (default).** At E17:
  - sum = (P0+P1)[15:0];
  - overflow = (P0+P1)[16].
  - Each operation overwrites the previous result.
- **Defined.** At E17, the block computes an 18-bit value {2'b0,sum} + P0 + P1. Then:
  - sum = result[15:0];
  - overflow = overflow | result[16] | result[17], so the flag is sticky until clr or reset.
- **Interface.** Ports and timing are identical in both builds.

## Test plan
- **Reset.** Hold Resetn=0 for 2 edges with start=1, then release. Required: sum=0000, overflow=0, busy=0, done=0, and no operation starts while reset is low.
- **Basic result.** a=3, b=4, c=5, d=6, start pulse at E0. Required: busy high for E1–E17, done pulse after E17, sum=16'h002A, overflow=0.
- **Overflow.** a=b=c=d=8'hFF. Required: sum=16'hFC02, overflow=1. With MAC_SEQ_ACCUM_EN, a second identical operation gives sum=16'hF804 and overflow=1.
- **Start while busy.** Pulse start again at E5 with different operands. Required: ignored; result equals that of the first operands; exactly one done pulse.
- **Clear mid-operation.** Assert clr at E10. Required: IDLE, busy=0, sum=0, overflow=0 next cycle; no done pulse; a new start afterwards completes normally in 17 cycles.
- **Accumulate (macro defined).** Run a=2, b=3, c=0, d=0, then a=1, b=1, c=1, d=1. Required: sum=0006 then 0008, overflow=0. With the macro undefined, the second result is 0002.
